// File: rtl/map_table_if.sv
// Dispatch, CDB and rename-result signals exchanged between the map table
// and the ROB/dispatch, free-list and reservation-station logic around it.
interface map_table_if #(
  parameter int CDB_WIDTH = 4
);
  logic [1:0]           rob_dispatch_num;
  logic [6:0]           fl_pr0;
  logic [6:0]           fl_pr1;
  logic                 rob_ar_a_valid;
  logic                 rob_ar_b_valid;
  logic                 rob_ar_a1_valid;
  logic                 rob_ar_a2_valid;
  logic                 rob_ar_b1_valid;
  logic                 rob_ar_b2_valid;
  logic [4:0]           rob_ar_a;
  logic [4:0]           rob_ar_b;
  logic [4:0]           rob_ar_a1;
  logic [4:0]           rob_ar_a2;
  logic [4:0]           rob_ar_b1;
  logic [4:0]           rob_ar_b2;
  logic [CDB_WIDTH-1:0] cdb_broadcast;
  logic [6:0]           cdb_pr_tag0;
  logic [6:0]           cdb_pr_tag1;
  logic [6:0]           cdb_pr_tag2;
  logic [6:0]           cdb_pr_tag3;
  logic [4:0]           cdb_ar_tag0;
  logic [4:0]           cdb_ar_tag1;
  logic [4:0]           cdb_ar_tag2;
  logic [4:0]           cdb_ar_tag3;
  logic [6:0]           rob_p0told;
  logic [6:0]           rob_p1told;
  logic [6:0]           rs_pr_a1;
  logic [6:0]           rs_pr_a2;
  logic [6:0]           rs_pr_b1;
  logic [6:0]           rs_pr_b2;
  logic                 rs_pr_a1_ready;
  logic                 rs_pr_a2_ready;
  logic                 rs_pr_b1_ready;
  logic                 rs_pr_b2_ready;

  modport master (
    output rob_dispatch_num, fl_pr0, fl_pr1,
    output rob_ar_a_valid, rob_ar_b_valid,
    output rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid,
    output rob_ar_a, rob_ar_b, rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2,
    output cdb_broadcast,
    output cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
    output cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3,
    input  rob_p0told, rob_p1told,
    input  rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2,
    input  rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready
  );

  modport slave (
    input  rob_dispatch_num, fl_pr0, fl_pr1,
    input  rob_ar_a_valid, rob_ar_b_valid,
    input  rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid,
    input  rob_ar_a, rob_ar_b, rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2,
    input  cdb_broadcast,
    input  cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
    input  cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3,
    output rob_p0told, rob_p1told,
    output rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2,
    output rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready
  );
endinterface

// File: rtl/map_table.sv
// R10K-style register map table: 32 AR -> 128 PR with ready bits, 2-wide
// rename with intra-group forwarding and CDB ready bypass.
module map_table #(
  parameter int CDB_WIDTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  map_table_if.slave   bus
);

  typedef struct packed {
    logic [6:0] pr;
    logic       ready;
  } entry_t;

  entry_t [31:0]    map_q;
  entry_t [31:0]    map_d;
  logic   [3:0]     laneValid;
  logic   [3:0][6:0] prTag;
  logic   [3:0][4:0] arTag;
  logic             dest0;
  logic             dest1;

  // Tag ports are always four lanes; lanes beyond CDB_WIDTH never fire.
  for (genvar k = 0; k < 4; k++) begin : gLane
    if (k < CDB_WIDTH) begin : gOn
      assign laneValid[k] = bus.cdb_broadcast[k];
    end else begin : gOff
      assign laneValid[k] = 1'b0;
    end
  end

  assign prTag = {bus.cdb_pr_tag3, bus.cdb_pr_tag2, bus.cdb_pr_tag1, bus.cdb_pr_tag0};
  assign arTag = {bus.cdb_ar_tag3, bus.cdb_ar_tag2, bus.cdb_ar_tag1, bus.cdb_ar_tag0};

  assign dest0 = (bus.rob_dispatch_num != 2'd0) && bus.rob_ar_a_valid;
  assign dest1 = bus.rob_dispatch_num[1] && bus.rob_ar_b_valid;

  function automatic logic cdbHit(input logic [6:0] pr, input logic [3:0] v,
                                  input logic [3:0][6:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v[k] && (tags[k] == pr)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic entry_t srcLookup(input logic valid, input logic [4:0] ar,
                                       input entry_t [31:0] m, input logic [3:0] v,
                                       input logic [3:0][6:0] tags);
    entry_t e;
    if (!valid) begin
      e = '{pr: 7'd0, ready: 1'b1};
    end else begin
      e.pr    = m[ar].pr;
      e.ready = m[ar].ready | cdbHit(m[ar].pr, v, tags);
    end
    return e;
  endfunction

  // Instruction 1 sees instruction 0's new PR when they name the same AR.
  always_comb begin
    entry_t a1, a2, b1, b2;
    a1 = srcLookup(bus.rob_ar_a1_valid, bus.rob_ar_a1, map_q, laneValid, prTag);
    a2 = srcLookup(bus.rob_ar_a2_valid, bus.rob_ar_a2, map_q, laneValid, prTag);
    b1 = srcLookup(bus.rob_ar_b1_valid, bus.rob_ar_b1, map_q, laneValid, prTag);
    b2 = srcLookup(bus.rob_ar_b2_valid, bus.rob_ar_b2, map_q, laneValid, prTag);
    if (bus.rob_ar_b1_valid && dest0 && (bus.rob_ar_b1 == bus.rob_ar_a)) begin
      b1 = '{pr: bus.fl_pr0, ready: 1'b0};
    end
    if (bus.rob_ar_b2_valid && dest0 && (bus.rob_ar_b2 == bus.rob_ar_a)) begin
      b2 = '{pr: bus.fl_pr0, ready: 1'b0};
    end
    bus.rob_p0told     = map_q[bus.rob_ar_a].pr;
    bus.rob_p1told     = (dest0 && (bus.rob_ar_b == bus.rob_ar_a)) ? bus.fl_pr0
                                                                    : map_q[bus.rob_ar_b].pr;
    bus.rs_pr_a1       = a1.pr;
    bus.rs_pr_a1_ready = a1.ready;
    bus.rs_pr_a2       = a2.pr;
    bus.rs_pr_a2_ready = a2.ready;
    bus.rs_pr_b1       = b1.pr;
    bus.rs_pr_b1_ready = b1.ready;
    bus.rs_pr_b2       = b2.pr;
    bus.rs_pr_b2_ready = b2.ready;
  end

  // Later assignments win: CDB ready-set, then instruction 0, then instruction 1.
  always_comb begin
    map_d = map_q;
    for (int k = 0; k < 4; k++) begin
      if (laneValid[k] && (map_q[arTag[k]].pr == prTag[k])) begin
        map_d[arTag[k]].ready = 1'b1;
      end
    end
    if (dest0) map_d[bus.rob_ar_a] = '{pr: bus.fl_pr0, ready: 1'b0};
    if (dest1) map_d[bus.rob_ar_b] = '{pr: bus.fl_pr1, ready: 1'b0};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        map_q[i] <= '{pr: 7'(i), ready: 1'b1};
      end
    end else begin
      map_q <= map_d;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Table-driven bench for map_table: each vector drives one cycle of inputs,
// checks the combinational outputs mid-cycle, then lets the edge update state.
module tb_map_table;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  map_table_if #(.CDB_WIDTH(4)) bus ();

  map_table #(.CDB_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] num;
    logic       aV;
    logic [4:0] arA;
    logic [6:0] fl0;
    logic       bV;
    logic [4:0] arB;
    logic [6:0] fl1;
    logic [3:0] srcV;
    logic [4:0] arA1, arA2, arB1, arB2;
    logic       cdbV;
    int         lane;
    logic [6:0] cdbPr;
    logic [4:0] cdbAr;
    logic [6:0] eP0, eP1, eA1, eA2, eB1, eB2;
    logic [3:0] eRdy;
  } vec_t;

  function automatic vec_t mk(
      input logic [1:0] num, input logic aV, input logic [4:0] arA, input logic [6:0] fl0,
      input logic bV, input logic [4:0] arB, input logic [6:0] fl1, input logic [3:0] srcV,
      input logic [4:0] arA1, input logic [4:0] arA2, input logic [4:0] arB1, input logic [4:0] arB2,
      input logic cdbV, input int lane, input logic [6:0] cdbPr, input logic [4:0] cdbAr,
      input logic [6:0] eP0, input logic [6:0] eP1, input logic [6:0] eA1, input logic [6:0] eA2,
      input logic [6:0] eB1, input logic [6:0] eB2, input logic [3:0] eRdy);
    vec_t v;
    v.num = num; v.aV = aV; v.arA = arA; v.fl0 = fl0;
    v.bV = bV; v.arB = arB; v.fl1 = fl1; v.srcV = srcV;
    v.arA1 = arA1; v.arA2 = arA2; v.arB1 = arB1; v.arB2 = arB2;
    v.cdbV = cdbV; v.lane = lane; v.cdbPr = cdbPr; v.cdbAr = cdbAr;
    v.eP0 = eP0; v.eP1 = eP1; v.eA1 = eA1; v.eA2 = eA2;
    v.eB1 = eB1; v.eB2 = eB2; v.eRdy = eRdy;
    return v;
  endfunction

  task automatic clearInputs();
    bus.rob_dispatch_num = 2'd0;
    bus.fl_pr0 = 7'd0;          bus.fl_pr1 = 7'd0;
    bus.rob_ar_a_valid = 1'b0;  bus.rob_ar_b_valid = 1'b0;
    bus.rob_ar_a1_valid = 1'b0; bus.rob_ar_a2_valid = 1'b0;
    bus.rob_ar_b1_valid = 1'b0; bus.rob_ar_b2_valid = 1'b0;
    bus.rob_ar_a = 5'd0;  bus.rob_ar_b = 5'd0;
    bus.rob_ar_a1 = 5'd0; bus.rob_ar_a2 = 5'd0;
    bus.rob_ar_b1 = 5'd0; bus.rob_ar_b2 = 5'd0;
    bus.cdb_broadcast = 4'd0;
    bus.cdb_pr_tag0 = 7'd0; bus.cdb_pr_tag1 = 7'd0;
    bus.cdb_pr_tag2 = 7'd0; bus.cdb_pr_tag3 = 7'd0;
    bus.cdb_ar_tag0 = 5'd0; bus.cdb_ar_tag1 = 5'd0;
    bus.cdb_ar_tag2 = 5'd0; bus.cdb_ar_tag3 = 5'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    bus.rob_dispatch_num = v.num;
    bus.rob_ar_a_valid = v.aV; bus.rob_ar_a = v.arA; bus.fl_pr0 = v.fl0;
    bus.rob_ar_b_valid = v.bV; bus.rob_ar_b = v.arB; bus.fl_pr1 = v.fl1;
    {bus.rob_ar_a1_valid, bus.rob_ar_a2_valid, bus.rob_ar_b1_valid, bus.rob_ar_b2_valid} = v.srcV;
    bus.rob_ar_a1 = v.arA1; bus.rob_ar_a2 = v.arA2;
    bus.rob_ar_b1 = v.arB1; bus.rob_ar_b2 = v.arB2;
    if (v.cdbV) begin
      bus.cdb_broadcast[v.lane] = 1'b1;
      case (v.lane)
        0: begin bus.cdb_pr_tag0 = v.cdbPr; bus.cdb_ar_tag0 = v.cdbAr; end
        1: begin bus.cdb_pr_tag1 = v.cdbPr; bus.cdb_ar_tag1 = v.cdbAr; end
        2: begin bus.cdb_pr_tag2 = v.cdbPr; bus.cdb_ar_tag2 = v.cdbAr; end
        default: begin bus.cdb_pr_tag3 = v.cdbPr; bus.cdb_ar_tag3 = v.cdbAr; end
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, ".p0told"}, int'(bus.rob_p0told), int'(v.eP0));
    checkOutput({tag, ".p1told"}, int'(bus.rob_p1told), int'(v.eP1));
    checkOutput({tag, ".pr_a1"},  int'(bus.rs_pr_a1),   int'(v.eA1));
    checkOutput({tag, ".pr_a2"},  int'(bus.rs_pr_a2),   int'(v.eA2));
    checkOutput({tag, ".pr_b1"},  int'(bus.rs_pr_b1),   int'(v.eB1));
    checkOutput({tag, ".pr_b2"},  int'(bus.rs_pr_b2),   int'(v.eB2));
    checkOutput({tag, ".rdy"},
                int'({bus.rs_pr_a1_ready, bus.rs_pr_a2_ready, bus.rs_pr_b1_ready, bus.rs_pr_b2_ready}),
                int'(v.eRdy));
  endtask

  vec_t vecs[$];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    clearInputs();

    //          num aV arA fl0 bV arB fl1 srcV     a1  a2  b1  b2 cdb ln pr  ar   P0  P1  A1  A2  B1  B2  rdy
    vecs.push_back(mk(0, 0, 5,  0, 0, 0,  0, 4'b1000, 5,  0,  0,  0, 0, 0, 0,  0,   5,  0,  5,  0,  0,  0, 4'b1111));
    vecs.push_back(mk(1, 1, 3, 40, 0, 0,  0, 4'b0000, 0,  0,  0,  0, 0, 0, 0,  0,   3,  0,  0,  0,  0,  0, 4'b1111));
    vecs.push_back(mk(0, 0, 3,  0, 0, 0,  0, 4'b1000, 3,  0,  0,  0, 0, 0, 0,  0,  40,  0, 40,  0,  0,  0, 4'b0111));
    vecs.push_back(mk(0, 0, 3,  0, 0, 0,  0, 4'b1000, 3,  0,  0,  0, 1, 2, 40, 3,  40,  0, 40,  0,  0,  0, 4'b1111));
    vecs.push_back(mk(0, 0, 3,  0, 0, 0,  0, 4'b1000, 3,  0,  0,  0, 0, 0, 0,  0,  40,  0, 40,  0,  0,  0, 4'b1111));
    vecs.push_back(mk(1, 1, 3, 42, 0, 0,  0, 4'b0000, 0,  0,  0,  0, 0, 0, 0,  0,  40,  0,  0,  0,  0,  0, 4'b1111));
    vecs.push_back(mk(0, 0, 3,  0, 0, 0,  0, 4'b1000, 3,  0,  0,  0, 1, 1, 41, 3,  42,  0, 42,  0,  0,  0, 4'b0111));
    vecs.push_back(mk(0, 0, 3,  0, 0, 0,  0, 4'b1000, 3,  0,  0,  0, 0, 0, 0,  0,  42,  0, 42,  0,  0,  0, 4'b0111));
    vecs.push_back(mk(2, 1, 7, 50, 1, 7, 51, 4'b0010, 0,  0,  7,  0, 0, 0, 0,  0,   7, 50,  0,  0, 50,  0, 4'b1101));
    vecs.push_back(mk(0, 0, 7,  0, 0, 0,  0, 4'b1000, 7,  0,  0,  0, 0, 0, 0,  0,  51,  0, 51,  0,  0,  0, 4'b0111));
    vecs.push_back(mk(1, 0, 0,  0, 1, 9, 70, 4'b0000, 0,  0,  0,  0, 0, 0, 0,  0,   0,  9,  0,  0,  0,  0, 4'b1111));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 4'b0101, 0,  9,  0,  3, 0, 0, 0,  0,   0,  0,  0,  9,  0, 42, 4'b1110));
    vecs.push_back(mk(0, 1, 9, 99, 0, 9,  0, 4'b0010, 0,  0,  9,  0, 0, 0, 0,  0,   9,  9,  0,  0,  9,  0, 4'b1111));
    vecs.push_back(mk(3, 1,10, 80, 1,11, 81, 4'b0000, 0,  0,  0,  0, 0, 0, 0,  0,  10, 11,  0,  0,  0,  0, 4'b1111));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 4'b1111,10, 11, 10, 11, 1, 0, 80,10,   0,  0, 80, 81, 80, 81, 4'b1010));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 4'b1100,10, 11,  0,  0, 0, 0, 0,  0,   0,  0, 80, 81,  0,  0, 4'b1011));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 4'b0100, 0, 11,  0,  0, 1, 3, 81,11,   0,  0,  0, 81,  0,  0, 4'b1111));

    repeat (2) @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
      @(posedge clock);
      @(negedge clock);
    end

    // Dispatch to ar 4 and a matching CDB on ar 4 land on the same edge.
    clearInputs();
    bus.rob_dispatch_num = 2'd1;
    bus.rob_ar_a_valid   = 1'b1;
    bus.rob_ar_a         = 5'd4;
    bus.fl_pr0           = 7'd60;
    bus.cdb_broadcast    = 4'b0001;
    bus.cdb_pr_tag0      = 7'd4;
    bus.cdb_ar_tag0      = 5'd4;
    @(posedge clock);
    @(negedge clock);
    clearInputs();
    bus.rob_ar_a1_valid = 1'b1;
    bus.rob_ar_a1       = 5'd4;
    bus.rob_ar_a        = 5'd7;
    #1;
    checkOutput("same_edge.pr",    int'(bus.rs_pr_a1),       60);
    checkOutput("same_edge.ready", int'(bus.rs_pr_a1_ready), 0);
    checkOutput("pre_reset.p0told7", int'(bus.rob_p0told),   51);

    // Reset mid-cycle must restore identity without waiting for a clock edge.
    reset = 1'b0;
    #1;
    checkOutput("async_reset.pr",    int'(bus.rs_pr_a1),       4);
    checkOutput("async_reset.ready", int'(bus.rs_pr_a1_ready), 1);
    checkOutput("async_reset.p0told7", int'(bus.rob_p0told),   7);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("after_reset.pr",    int'(bus.rs_pr_a1),       4);
    checkOutput("after_reset.p0told7", int'(bus.rob_p0told),   7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
